// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_unit
// Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
//            Optional macro DIV_ZERO_FAST_EN: divide-by-zero commits after 1 cycle.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit #(
   parameter int unsigned MULT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_content,
   input  logic [31:0] rt_content,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   localparam int unsigned c_div_cycles = 33;
   localparam logic [5:0]  c_mul_last   = 6'(MULT_CYCLES - 1);
   localparam logic [5:0]  c_div_fix    = 6'(c_div_cycles - 1);

   state_t      r_state;
   logic [5:0]  r_cnt;
   logic        r_signed;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic        r_neg_q;
   logic        r_neg_r;
   logic        r_dz;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_busy;
   logic        r_done;

   logic        w_signed;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_load;
   logic [5:0]  w_div_cnt0;
   logic [63:0] w_mul_a;
   logic [63:0] w_mul_b;
   logic [63:0] w_prod;
   logic [32:0] w_shift;
   logic [32:0] w_diff;
   logic [31:0] w_q;
   logic [31:0] w_r;

   assign w_signed = ~op[0];
   assign w_a_neg  = w_signed & rs_content[31];
   assign w_b_neg  = w_signed & rt_content[31];
   assign w_a_mag  = w_a_neg ? (~rs_content + 32'd1) : rs_content;
   // Divides keep the divisor magnitude in r_b; multiplies keep it raw.
   assign w_b_load = (op[1] & w_b_neg) ? (~rt_content + 32'd1) : rt_content;

`ifdef DIV_ZERO_FAST_EN
   assign w_div_cnt0 = (rt_content == 32'd0) ? c_div_fix : 6'd0;
`else
   assign w_div_cnt0 = 6'd0;
`endif

   assign w_mul_a = {{32{r_a[31] & r_signed}}, r_a};
   assign w_mul_b = {{32{r_b[31] & r_signed}}, r_b};
   assign w_prod  = w_mul_a * w_mul_b;

   // Restoring step: shift in next dividend bit, subtract if it fits.
   assign w_shift = {r_rem, r_quo[31]};
   assign w_diff  = w_shift - {1'b0, r_b};

   assign w_q = r_neg_q ? (~r_quo + 32'd1) : r_quo;
   assign w_r = r_neg_r ? (~r_rem + 32'd1) : r_rem;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= 6'd0;
         r_signed <= 1'b0;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_rem    <= 32'd0;
         r_quo    <= 32'd0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dz     <= 1'b0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_signed <= w_signed;
                  r_a      <= rs_content;
                  r_b      <= w_b_load;
                  r_quo    <= w_a_mag;
                  r_rem    <= 32'd0;
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_dz     <= (rt_content == 32'd0);
                  r_busy   <= 1'b1;
                  r_cnt    <= op[1] ? w_div_cnt0 : 6'd0;
                  r_state  <= op[1] ? S_DIV : S_MUL;
               end else begin
                  if (mthi) r_hi <= wdata;
                  if (mtlo) r_lo <= wdata;
               end
            end
            S_MUL: begin
               if (r_cnt == c_mul_last) begin
                  {r_hi, r_lo} <= w_prod;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_cnt   <= 6'd0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            S_DIV: begin
               if (r_cnt == c_div_fix) begin
                  if (r_dz) begin
                     r_lo <= 32'hFFFF_FFFF;
                     r_hi <= r_a;
                  end else begin
                     r_lo <= w_q;
                     r_hi <= w_r;
                  end
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_cnt   <= 6'd0;
                  r_state <= S_IDLE;
               end else begin
                  if (!w_diff[32]) begin
                     r_rem <= w_diff[31:0];
                     r_quo <= {r_quo[30:0], 1'b1};
                  end else begin
                     r_rem <= w_shift[31:0];
                     r_quo <= {r_quo[30:0], 1'b0};
                  end
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_muldiv_unit
// Purpose  : Scoreboard bench for hilo_muldiv_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_unit;

   localparam int c_mc = 4;
   localparam int c_dc = 33;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_content;
   logic [31:0] rt_content;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   hilo_muldiv_unit #(.MULT_CYCLES(c_mc)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rs_content(rs_content), .rt_content(rt_content),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          at;
   } exp_t;

   exp_t        scb[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Architectural result: {hi, lo} for one instruction.
   function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] qv, rv;
      case (o)
         2'b00: begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
         end
         2'b01: return {32'd0, a} * {32'd0, b};
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (o == 2'b10) begin
               sa = longint'($signed(a));
               sb = longint'($signed(b));
            end else begin
               sa = longint'({32'd0, a});
               sb = longint'({32'd0, b});
            end
            q  = sa / sb;
            r  = sa % sb;
            qv = 64'(q);
            rv = 64'(r);
            return {rv[31:0], qv[31:0]};
         end
      endcase
   endfunction

   function automatic int latency(input logic [1:0] o, input logic [31:0] b);
      if (!o[1]) return c_mc;
`ifdef DIV_ZERO_FAST_EN
      if (b == 32'd0) return 1;
`else
      if (b == 32'd0) return c_dc;
`endif
      return c_dc;
   endfunction

   // Monitor: every done pulse consumes one expected commit.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (scb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_done: got done=1 want no commit (cycle %0d)", cyc);
            end else begin
               e = scb.pop_front();
               check("commit_hi", hi, e.hi);
               check("commit_lo", lo, e.lo);
               check("commit_cycle", 32'(cyc), 32'(e.at));
               check("busy_on_done", {31'd0, busy}, 32'd0);
            end
         end
      end
   end

   // poke: 0 none, 1 mtlo with start, 2 second start mid-op, 3 mthi mid-op
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int poke);
      logic [31:0] ph, pl;
      logic [63:0] r;
      exp_t        e;
      int          n;
      ph = m_hi;
      pl = m_lo;
      r  = ref_op(o, a, b);
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.at = cyc + 1 + latency(o, b);
      scb.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
      start = 1'b1;
      op = o;
      rs_content = a;
      rt_content = b;
      if (poke == 1) begin
         mtlo  = 1'b1;
         wdata = 32'h5555_0000 ^ a;
      end
      @(negedge clk);
      start = 1'b0;
      mtlo  = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      n = 0;
      while (busy === 1'b1 && n < 60) begin
         check("hold_hi", hi, ph);
         check("hold_lo", lo, pl);
         n++;
         if (poke == 2 && n == 2) begin
            start = 1'b1;
            op = 2'b01;
            rs_content = 32'h1234;
            rt_content = 32'h10;
         end else if (poke == 3 && n == 2) begin
            mthi  = 1'b1;
            wdata = 32'hAAAA;
         end
         @(negedge clk);
         start = 1'b0;
         mthi  = 1'b0;
      end
      if (n >= 60) begin
         total++;
         bad++;
         $display("FAIL busy_timeout: got busy=1 after %0d cycles want 0", n);
      end
   endtask

   task automatic mt(input logic h, input logic l, input logic [31:0] d);
      mthi  = h;
      mtlo  = l;
      wdata = d;
      @(negedge clk);
      mthi = 1'b0;
      mtlo = 1'b0;
      if (h) m_hi = d;
      if (l) m_lo = d;
      check("mt_hi", hi, m_hi);
      check("mt_lo", lo, m_lo);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_hi"}, hi, 32'd0);
      check({tag, "_lo"}, lo, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [1:0]  o;
      logic [31:0] a, b;
      int          sel;
      reset = 1'b1;
      start = 1'b0;
      op = 2'b00;
      rs_content = 32'd0;
      rt_content = 32'd0;
      mthi = 1'b0;
      mtlo = 1'b0;
      wdata = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_reset_state("reset");

      issue(2'b00, 32'hFFFF_FFFE, 32'd3, 0);
      issue(2'b01, 32'hFFFF_FFFE, 32'd3, 0);
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
      issue(2'b11, 32'd7, 32'd2, 0);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      issue(2'b11, 32'd5, 32'd0, 0);
      issue(2'b10, 32'hFFFF_FFF0, 32'd0, 0);
      issue(2'b00, 32'd12345, 32'd678, 2);
      issue(2'b01, 32'hDEAD_BEEF, 32'h0000_0100, 3);
      mt(1'b0, 1'b1, 32'h0000_1234);
      issue(2'b01, 32'h10, 32'h20, 1);
      mt(1'b1, 1'b1, 32'hCAFE_F00D);

      for (int k = 0; k < 24; k++) begin
         o   = 2'($urandom_range(0, 3));
         a   = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0)      b = 32'd0;
         else if (sel == 1) b = 32'($urandom_range(1, 9));
         else if (sel == 2) b = 32'hFFFF_FFFF;
         else               b = $urandom;
         if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if ($urandom_range(0, 3) == 0) mt(1'($urandom), 1'($urandom), $urandom);
         issue(o, a, b, 0);
      end

      // Asynchronous reset mid-cycle, outputs must clear before the next edge.
      @(posedge clk);
      #3 reset = 1'b1;
      #1 check_reset_state("async_reset");
      @(negedge clk);
      reset = 1'b0;
      m_hi = 32'd0;
      m_lo = 32'd0;

      mt(1'b1, 1'b1, 32'h0BAD_0BAD);
      start = 1'b1;
      op = 2'b10;
      rs_content = 32'd1000;
      rt_content = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #3 reset = 1'b1;
      #1 check_reset_state("abort");
      @(negedge clk);
      reset = 1'b0;
      m_hi = 32'd0;
      m_lo = 32'd0;
      repeat (40) @(negedge clk);
      check_reset_state("abort_quiet");
      issue(2'b01, 32'd3, 32'd4, 0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(scb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
